// File: rtl/reflet_float_mem_arbiter_if.sv
// Bus bundle for the reflet float memory arbiter: both requester ports,
// the shared memory port and the busy flag.
interface reflet_float_mem_arbiter_if #(
  parameter int float_size  = 32,
  parameter int addr_size   = 32,
  parameter int stack_depth = 128
);
  localparam int SW = $clog2(stack_depth);

  logic                  inst_req;
  logic [addr_size-1:0]  inst_addr;
  logic [float_size-1:0] inst_data;
  logic                  inst_ready;

  logic                  stack_req;
  logic                  stack_write_en;
  logic [SW-1:0]         stack_addr;
  logic [float_size-1:0] stack_wdata;
  logic [float_size-1:0] stack_rdata;
  logic                  stack_ready;

  logic [addr_size-1:0]  mem_addr;
  logic [float_size-1:0] mem_wdata;
  logic                  mem_enable;
  logic                  mem_write_en;
  logic [float_size-1:0] mem_rdata;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  inst_req, inst_addr, stack_req, stack_write_en, stack_addr, stack_wdata, mem_rdata,
    output inst_data, inst_ready, stack_rdata, stack_ready,
           mem_addr, mem_wdata, mem_enable, mem_write_en, busy
  );

  // Requester / memory side
  modport master (
    output inst_req, inst_addr, stack_req, stack_write_en, stack_addr, stack_wdata, mem_rdata,
    input  inst_data, inst_ready, stack_rdata, stack_ready,
           mem_addr, mem_wdata, mem_enable, mem_write_en, busy
  );
endinterface

// File: rtl/reflet_float_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction
// fetch port and the stack port; each access takes IDLE->ISSUE->CAPTURE->DONE.
module reflet_float_mem_arbiter #(
  parameter int                   float_size  = 32,
  parameter int                   addr_size   = 32,
  parameter int                   stack_depth = 128,
  parameter logic [addr_size-1:0] stack_base  = 'h0000_1000
) (
  input  logic clk,
  input  logic reset,
  reflet_float_mem_arbiter_if.slave bus
);
  localparam int BPW = float_size / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_stack_q, last_stack_d;
  logic                  gnt_stack_q, gnt_stack_d;
  logic                  wr_q, wr_d;
  logic [addr_size-1:0]  mem_addr_q, mem_addr_d;
  logic [float_size-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [float_size-1:0] inst_data_q, inst_data_d;
  logic [float_size-1:0] stack_rdata_q, stack_rdata_d;
  logic                  inst_rdy_q, inst_rdy_d;
  logic                  stack_rdy_q, stack_rdy_d;
  logic                  busy_q, busy_d;

  logic [addr_size-1:0]  stack_byte_addr;
  logic                  pick_stack;

  always_comb begin
    // Wraps modulo 2^addr_size by construction of the operand widths
    stack_byte_addr = stack_base + addr_size'(bus.stack_addr) * addr_size'(BPW);
    // Stack wins only if alone or if the instruction port was granted last
    pick_stack      = bus.stack_req & (~bus.inst_req | ~last_stack_q);

    state_d       = state_q;
    last_stack_d  = last_stack_q;
    gnt_stack_d   = gnt_stack_q;
    wr_d          = wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    inst_data_d   = inst_data_q;
    stack_rdata_d = stack_rdata_q;
    inst_rdy_d    = 1'b0;
    stack_rdy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.inst_req || bus.stack_req) begin
          state_d      = ISSUE;
          gnt_stack_d  = pick_stack;
          last_stack_d = pick_stack;
          wr_d         = pick_stack & bus.stack_write_en;
          mem_addr_d   = pick_stack ? stack_byte_addr : bus.inst_addr;
          if (pick_stack) mem_wdata_d = bus.stack_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = pick_stack & bus.stack_write_en;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        if (!wr_q) begin
          if (gnt_stack_q) stack_rdata_d = bus.mem_rdata;
          else             inst_data_d   = bus.mem_rdata;
        end
        inst_rdy_d  = ~gnt_stack_q;
        stack_rdy_d = gnt_stack_q;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_stack_q  <= 1'b1;
      gnt_stack_q   <= 1'b0;
      wr_q          <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      inst_data_q   <= '0;
      stack_rdata_q <= '0;
      inst_rdy_q    <= 1'b0;
      stack_rdy_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_stack_q  <= last_stack_d;
      gnt_stack_q   <= gnt_stack_d;
      wr_q          <= wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      inst_data_q   <= inst_data_d;
      stack_rdata_q <= stack_rdata_d;
      inst_rdy_q    <= inst_rdy_d;
      stack_rdy_q   <= stack_rdy_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_enable   = mem_en_q;
  assign bus.mem_write_en = mem_we_q;
  assign bus.inst_data    = inst_data_q;
  assign bus.stack_rdata  = stack_rdata_q;
  assign bus.inst_ready   = inst_rdy_q;
  assign bus.stack_ready  = stack_rdy_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_reflet_float_mem_arbiter.sv
// Directed bench for reflet_float_mem_arbiter: arbitration order, address
// mapping, data hold, reset abort and stack address wrap.
module tb_reflet_float_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reflet_float_mem_arbiter_if #(.float_size(32), .addr_size(32), .stack_depth(128)) a ();
  reflet_float_mem_arbiter_if #(.float_size(32), .addr_size(32), .stack_depth(128)) b ();

  reflet_float_mem_arbiter #(
    .float_size(32), .addr_size(32), .stack_depth(128), .stack_base(32'h0000_1000)
  ) u_dut (.clk(clk), .reset(reset), .bus(a.slave));

  reflet_float_mem_arbiter #(
    .float_size(32), .addr_size(32), .stack_depth(128), .stack_base(32'hFFFF_FFF8)
  ) u_wrap (.clk(clk), .reset(reset), .bus(b.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Continuous protocol checks on the main instance
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    chk("en_back_to_back", {63'd0, prev_en & a.mem_enable}, 64'd0);
    chk("both_ready", {63'd0, a.inst_ready & a.stack_ready}, 64'd0);
    chk("we_without_en", {63'd0, a.mem_write_en & ~a.mem_enable}, 64'd0);
    prev_en = a.mem_enable;
  end

  initial begin
    a.inst_req = 0; a.inst_addr = 0; a.stack_req = 0; a.stack_write_en = 0;
    a.stack_addr = 0; a.stack_wdata = 0; a.mem_rdata = 0;
    b.inst_req = 0; b.inst_addr = 0; b.stack_req = 0; b.stack_write_en = 0;
    b.stack_addr = 0; b.stack_wdata = 0; b.mem_rdata = 0;

    step(); step();
    chk("rst_busy", a.busy, 0);
    chk("rst_en", a.mem_enable, 0);
    chk("rst_we", a.mem_write_en, 0);
    chk("rst_addr", a.mem_addr, 0);
    chk("rst_wdata", a.mem_wdata, 0);
    chk("rst_inst_data", a.inst_data, 0);
    chk("rst_stack_rdata", a.stack_rdata, 0);
    chk("rst_inst_ready", a.inst_ready, 0);
    chk("rst_stack_ready", a.stack_ready, 0);

    // First tie after reset: instruction port first
    reset = 0;
    a.inst_req = 1; a.inst_addr = 32'h80;
    a.stack_req = 1; a.stack_addr = 2; a.stack_write_en = 0;
    a.mem_rdata = 32'h1111_1111;
    step();
    chk("tie1_inst_addr", a.mem_addr, 32'h80);
    chk("tie1_inst_en", a.mem_enable, 1);
    chk("tie1_busy", a.busy, 1);
    step();
    chk("tie1_capture_en", a.mem_enable, 0);
    step();
    chk("tie1_inst_ready", a.inst_ready, 1);
    chk("tie1_stack_not_ready", a.stack_ready, 0);
    chk("tie1_inst_data", a.inst_data, 32'h1111_1111);
    a.inst_req = 0; a.mem_rdata = 32'h2222_2222;
    step();
    chk("tie1_idle", a.busy, 0);
    chk("tie1_ready_drop", a.inst_ready, 0);
    step();
    chk("tie1_stack_addr", a.mem_addr, 32'h1008);
    chk("tie1_stack_en", a.mem_enable, 1);
    step(); step();
    chk("tie1_stack_ready", a.stack_ready, 1);
    chk("tie1_stack_rdata", a.stack_rdata, 32'h2222_2222);
    a.stack_req = 0;
    step();

    // Stack write: leaves stack_rdata alone
    a.stack_req = 1; a.stack_write_en = 1; a.stack_addr = 5; a.stack_wdata = 32'h4049_0FDB;
    step();
    chk("wr_addr", a.mem_addr, 32'h1014);
    chk("wr_we", a.mem_write_en, 1);
    chk("wr_en", a.mem_enable, 1);
    chk("wr_wdata", a.mem_wdata, 32'h4049_0FDB);
    step();
    chk("wr_we_drop", a.mem_write_en, 0);
    step();
    chk("wr_stack_ready", a.stack_ready, 1);
    chk("wr_rdata_hold", a.stack_rdata, 32'h2222_2222);
    a.stack_req = 0; a.stack_write_en = 0;
    step();

    // Single instruction fetch
    a.inst_req = 1; a.inst_addr = 32'h40; a.mem_rdata = 32'h3F80_0000;
    step();
    chk("if_addr", a.mem_addr, 32'h40);
    chk("if_en", a.mem_enable, 1);
    chk("if_we", a.mem_write_en, 0);
    step(); step();
    chk("if_ready", a.inst_ready, 1);
    chk("if_data", a.inst_data, 32'h3F80_0000);
    chk("if_stack_hold", a.stack_rdata, 32'h2222_2222);
    a.inst_req = 0;
    step();

    // Second tie after an instruction grant: stack port first
    a.inst_req = 1; a.inst_addr = 32'h44;
    a.stack_req = 1; a.stack_addr = 7; a.mem_rdata = 32'hC000_0000;
    step();
    chk("tie2_stack_addr", a.mem_addr, 32'h101C);
    step(); step();
    chk("tie2_stack_ready", a.stack_ready, 1);
    chk("tie2_inst_not_ready", a.inst_ready, 0);
    chk("tie2_stack_rdata", a.stack_rdata, 32'hC000_0000);
    chk("tie2_inst_hold", a.inst_data, 32'h3F80_0000);
    a.stack_req = 0; a.mem_rdata = 32'h4000_0000;
    step();
    step();
    chk("tie2_inst_addr", a.mem_addr, 32'h44);
    step(); step();
    chk("tie2_inst_ready", a.inst_ready, 1);
    chk("tie2_inst_data", a.inst_data, 32'h4000_0000);
    a.inst_req = 0;
    step();

    // Reset during CAPTURE of a stack read
    a.stack_req = 1; a.stack_addr = 1; a.mem_rdata = 32'hDEAD_BEEF;
    step(); step();
    reset = 1; a.stack_req = 0;
    step();
    chk("abort_busy", a.busy, 0);
    chk("abort_no_ready", a.stack_ready, 0);
    chk("abort_rdata", a.stack_rdata, 0);
    chk("abort_en", a.mem_enable, 0);
    reset = 0;
    step();
    chk("abort_no_late_ready", a.stack_ready, 0);
    a.inst_req = 1; a.inst_addr = 32'h100; a.mem_rdata = 32'h1234_5678;
    step();
    chk("post_abort_addr", a.mem_addr, 32'h100);
    step(); step();
    chk("post_abort_ready", a.inst_ready, 1);
    chk("post_abort_data", a.inst_data, 32'h1234_5678);
    a.inst_req = 0;
    step();

    // Request withdrawn right after being sampled
    a.inst_req = 1; a.inst_addr = 32'h200; a.mem_rdata = 32'hA5A5_A5A5;
    step();
    chk("drop_en", a.mem_enable, 1);
    a.inst_req = 0;
    step(); step();
    chk("drop_ready", a.inst_ready, 1);
    chk("drop_data", a.inst_data, 32'hA5A5_A5A5);
    step();
    chk("drop_ready_once", a.inst_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_no_en", a.mem_enable, 0);
      chk("drop_idle", a.busy, 0);
    end

    // Stack region near the top of the address space wraps to low memory
    b.stack_req = 1; b.stack_addr = 3;
    step();
    chk("wrap_addr", b.mem_addr, 32'h0000_0004);
    chk("wrap_en", b.mem_enable, 1);
    b.stack_req = 0;
    step(); step();
    chk("wrap_ready", b.stack_ready, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
